// File: rtl/des_subkey_generator.sv
// -----------------------------------------------------------------------------
// des_subkey_generator
//
// Sequential DES key schedule. A KEY_LOAD pulse captures a 64-bit key and a
// direction. The block then offers one 48-bit subkey per handshake:
//   - encrypt (DECRYPT=0): K1..K16, with C/D rotating left;
//   - decrypt (DECRYPT=1): K16..K1, with C/D rotating right.
// The round datapath can therefore be reused unchanged in both directions.
//
// Bit numbering follows the DES standard with bit 1 as the MSB:
//   KEY_IN[65-n]     = DES key bit n (parity bits 8,16,..,64 are ignored)
//   SUBKEY_OUT[49-n] = subkey bit n ([48:43] feeds S1, [6:1] feeds S8)
//
// Ports:
//   CLK           rising-edge clock
//   RST_N         asynchronous active-low reset
//   KEY_LOAD      start pulse; samples KEY_IN and DECRYPT (aborts a running
//                 sequence and restarts from the new key)
//   KEY_IN        64-bit DES key
//   DECRYPT       direction, sampled only together with KEY_LOAD
//   SUBKEY_READY  consumer accepts the offered subkey
//   SUBKEY_OUT    PC-2 of the current C/D registers (combinational)
//   SUBKEY_VALID  SUBKEY_OUT holds a valid subkey
//   ROUND_NUM     issue-order index of the offered subkey, 0..15
//   DONE          one-cycle pulse after the 16th subkey is accepted
//
// Build option:
//   SUBKEY_ZEROIZE_EN  when defined, SUBKEY_OUT reads 0 whenever no subkey
//                      is offered, and C/D are cleared on the completion edge
//                      so no key material lingers in the registers.
// -----------------------------------------------------------------------------
module des_subkey_generator (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        KEY_LOAD,
   input  logic [64:1] KEY_IN,
   input  logic        DECRYPT,
   input  logic        SUBKEY_READY,
   output logic [48:1] SUBKEY_OUT,
   output logic        SUBKEY_VALID,
   output logic [3:0]  ROUND_NUM,
   output logic        DONE
);

   // --------------------------------------------------------------------------
   // Fixed DES permutations. Entries are DES bit numbers (1 = MSB).
   // --------------------------------------------------------------------------
   localparam int PC1_TBL [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [0:47] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

   // --------------------------------------------------------------------------
   // Permutation and rotation helpers. C and D are kept MSB-first, so
   // register bit [28] is DES bit 1 of that half.
   // --------------------------------------------------------------------------
   function automatic logic [56:1] pc1(input logic [64:1] key);
      logic [56:1] cd;
      cd = '0;
      for (int i = 0; i < 56; i++) begin
         cd[56 - i] = key[65 - PC1_TBL[i]];
      end
      return cd;
   endfunction

   function automatic logic [48:1] pc2(input logic [56:1] cd);
      logic [48:1] k;
      k = '0;
      for (int i = 0; i < 48; i++) begin
         k[48 - i] = cd[57 - PC2_TBL[i]];
      end
      return k;
   endfunction

   // Rotate one 28-bit half by 1 or 2 positions in either direction.
   function automatic logic [28:1] rot28(input logic [28:1] x,
                                         input logic        left,
                                         input logic        by_two);
      logic [28:1] r;
      unique case ({left, by_two})
         2'b11:   r = {x[26:1], x[28:27]};
         2'b10:   r = {x[27:1], x[28]};
         2'b01:   r = {x[2:1], x[28:3]};
         default: r = {x[1], x[28:2]};
      endcase
      return r;
   endfunction

   // Rotation amount when stepping to issue index r (1..15). The encrypt
   // left-shift table and the decrypt right-shift table agree for r >= 1:
   // single steps at indices 1, 8 and 15, double steps everywhere else.
   function automatic logic step_is_two(input logic [3:0] r);
      return !((r == 4'd1) || (r == 4'd8) || (r == 4'd15));
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   state_e      state_q, state_d;
   logic [28:1] c_q, c_d;
   logic [28:1] d_q, d_d;
   logic [3:0]  round_q, round_d;
   logic        decrypt_q, decrypt_d;
   logic        done_q, done_d;

   logic [56:1] cd_load;
   logic [3:0]  round_nxt;
   logic        handshake;

   // Parity bits of the key take no part in the schedule.
   logic unused_parity;
   assign unused_parity = ^{KEY_IN[57], KEY_IN[49], KEY_IN[41], KEY_IN[33],
                            KEY_IN[25], KEY_IN[17], KEY_IN[9],  KEY_IN[1]};

   assign cd_load   = pc1(KEY_IN);
   assign round_nxt = round_q + 4'd1;
   assign handshake = (state_q == ST_ISSUE) && SUBKEY_READY;

   // NOTE: every signal assigned in this block gets its hold value first, so
   // no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      d_d       = d_q;
      round_d   = round_q;
      decrypt_d = decrypt_q;
      done_d    = 1'b0;

      if (KEY_LOAD) begin
         // A load restarts from any state and wins over a same-cycle
         // handshake; the aborted sequence never pulses DONE. Encrypt starts
         // pre-rotated by one so K1 is offered straight away; decrypt starts
         // from the unrotated value, which equals C16/D16 (28 total shifts).
         state_d   = ST_ISSUE;
         round_d   = 4'd0;
         decrypt_d = DECRYPT;
         if (DECRYPT) begin
            c_d = cd_load[56:29];
            d_d = cd_load[28:1];
         end else begin
            c_d = rot28(cd_load[56:29], 1'b1, 1'b0);
            d_d = rot28(cd_load[28:1],  1'b1, 1'b0);
         end
      end else if (handshake) begin
         if (round_q == 4'd15) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
            done_d  = 1'b1;
`ifdef SUBKEY_ZEROIZE_EN
            c_d = '0;
            d_d = '0;
`endif
         end else begin
            round_d = round_nxt;
            c_d     = rot28(c_q, !decrypt_q, step_is_two(round_nxt));
            d_d     = rot28(d_q, !decrypt_q, step_is_two(round_nxt));
         end
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples the values from before the clock edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         c_q       <= '0;
         d_q       <= '0;
         round_q   <= 4'd0;
         decrypt_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         d_q       <= d_d;
         round_q   <= round_d;
         decrypt_q <= decrypt_d;
         done_q    <= done_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs. VALID follows the state register directly, so reset clears it
   // asynchronously. SUBKEY_OUT depends on registers only.
   // --------------------------------------------------------------------------
   assign SUBKEY_VALID = (state_q == ST_ISSUE);
   assign ROUND_NUM    = round_q;
   assign DONE         = done_q;

`ifdef SUBKEY_ZEROIZE_EN
   assign SUBKEY_OUT = SUBKEY_VALID ? pc2({c_q, d_q}) : '0;
`else
   assign SUBKEY_OUT = pc2({c_q, d_q});
`endif

endmodule

// File: tb/tb_des_subkey_generator.sv
// -----------------------------------------------------------------------------
// tb_des_subkey_generator
//
// Self-checking bench for des_subkey_generator. A reference model computes
// each subkey K_n directly from the key: the cumulative left rotation after
// n rounds is applied as a modular index into the PC-1 selection, then PC-2
// picks the subkey bits. Issue order is K1..K16 or K16..K1. Outputs are
// compared on every falling edge against that model; directed sections pin
// the model against the published DES test-vector subkeys.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_des_subkey_generator;

   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam logic [64:1] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [48:1] K1_A  = 48'h1B02EFFC7072;
   localparam logic [48:1] K2_A  = 48'h79AED9DBC9E5;
   localparam logic [48:1] K16_A = 48'hCB3D8B0E17F5;

   logic        CLK;
   logic        RST_N;
   logic        KEY_LOAD;
   logic [64:1] KEY_IN;
   logic        DECRYPT;
   logic        SUBKEY_READY;
   logic [48:1] SUBKEY_OUT;
   logic        SUBKEY_VALID;
   logic [3:0]  ROUND_NUM;
   logic        DONE;

   des_subkey_generator dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .KEY_LOAD     (KEY_LOAD),
      .KEY_IN       (KEY_IN),
      .DECRYPT      (DECRYPT),
      .SUBKEY_READY (SUBKEY_READY),
      .SUBKEY_OUT   (SUBKEY_OUT),
      .SUBKEY_VALID (SUBKEY_VALID),
      .ROUND_NUM    (ROUND_NUM),
      .DONE         (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: what the outputs must show after the most
   // recent rising edge.
   logic [48:1] m_keys [0:15];
   logic        m_active;
   int          m_idx;
   logic        m_done;
   logic [48:1] m_idle_out;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Subkey K_n (n = 1..16) straight from the key.
   function automatic logic [48:1] des_subkey(input logic [64:1] key, input int n);
      logic [48:1] k;
      int total;
      int cbit;
      int pos;
      total = 0;
      for (int i = 0; i < n; i++) total += SHIFTS[i];
      k = '0;
      for (int b = 1; b <= 48; b++) begin
         cbit = PC2[b - 1];
         if (cbit <= 28) pos = PC1[(cbit - 1 + total) % 28];
         else            pos = PC1[28 + ((cbit - 29 + total) % 28)];
         k[49 - b] = key[65 - pos];
      end
      return k;
   endfunction

   task automatic model_reset();
      m_active   = 1'b0;
      m_idx      = 0;
      m_done     = 1'b0;
      m_idle_out = '0;
   endtask

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input logic ld, input logic [64:1] k, input logic dec, input logic rdy);
      m_done = 1'b0;
      if (ld) begin
         for (int r = 0; r < 16; r++)
            m_keys[r] = dec ? des_subkey(k, 16 - r) : des_subkey(k, r + 1);
         m_active = 1'b1;
         m_idx    = 0;
      end else if (m_active && rdy) begin
         if (m_idx == 15) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_done   = 1'b1;
`ifdef SUBKEY_ZEROIZE_EN
            m_idle_out = '0;
`else
            m_idle_out = m_keys[15];
`endif
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic compare_all();
      logic [48:1] exp_key;
      exp_key = m_active ? m_keys[m_idx] : m_idle_out;
      check("valid",  64'(SUBKEY_VALID), 64'(m_active));
      check("round",  64'(ROUND_NUM),    64'(m_idx));
      check("done",   64'(DONE),         64'(m_done));
      check("subkey", 64'(SUBKEY_OUT),   64'(exp_key));
   endtask

   // Drive one cycle's inputs, let the rising edge happen, then compare on
   // the following falling edge.
   task automatic cycle(input logic ld, input logic [64:1] k, input logic dec, input logic rdy);
      KEY_LOAD     = ld;
      KEY_IN       = k;
      DECRYPT      = dec;
      SUBKEY_READY = rdy;
      model_edge(ld, k, dec, rdy);
      @(negedge CLK);
      compare_all();
   endtask

   task automatic load_and_advance(input logic [64:1] k, input logic dec, input int n);
      cycle(1'b1, k, dec, 1'b1);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic run_to_done();
      int guard;
      guard = 0;
      while (m_active && guard < 40) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         guard++;
      end
      if (m_active) check("run_to_done_bound", 64'(1), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [64:1] rkey;
      logic        rld;
      logic        rdec;
      logic        rrdy;

      RST_N        = 1'b0;
      KEY_LOAD     = 1'b0;
      KEY_IN       = '0;
      DECRYPT      = 1'b0;
      SUBKEY_READY = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge CLK);
      RST_N = 1'b1;

      // Encrypt, published key: K1, K2, K16, DONE at t+17.
      cycle(1'b1, KEY_A, 1'b0, 1'b1);
      check("model_k1", 64'(m_keys[0]),  64'(K1_A));
      check("model_k16", 64'(m_keys[15]), 64'(K16_A));
      check("enc_first", 64'(SUBKEY_OUT), 64'(K1_A));
      check("enc_first_round", 64'(ROUND_NUM), 64'(0));
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("enc_second", 64'(SUBKEY_OUT), 64'(K2_A));
      for (int i = 0; i < 14; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      check("enc_sixteenth", 64'(SUBKEY_OUT), 64'(K16_A));
      check("enc_sixteenth_round", 64'(ROUND_NUM), 64'(15));
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("enc_done", 64'(DONE), 64'(1));
`ifdef SUBKEY_ZEROIZE_EN
      check("enc_idle_out", 64'(SUBKEY_OUT), 64'(0));
`else
      check("enc_idle_out", 64'(SUBKEY_OUT), 64'(K16_A));
`endif

      // Decrypt, same key, loaded in the DONE cycle.
      cycle(1'b1, KEY_A, 1'b1, 1'b1);
      check("dec_first", 64'(SUBKEY_OUT), 64'(K16_A));
      for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      check("dec_last", 64'(SUBKEY_OUT), 64'(K1_A));
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("dec_done", 64'(DONE), 64'(1));
`ifdef SUBKEY_ZEROIZE_EN
      check("dec_idle_out", 64'(SUBKEY_OUT), 64'(0));
`else
      check("dec_idle_out", 64'(SUBKEY_OUT), 64'(K1_A));
`endif
      cycle(1'b0, '0, 1'b0, 1'b0);

      // Backpressure at round 4 for three cycles.
      load_and_advance(64'h0E329232EA6D0D73, 1'b0, 4);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      check("hold_round", 64'(ROUND_NUM), 64'(4));
      run_to_done();
      cycle(1'b0, '0, 1'b0, 1'b0);

      // Abort at round 7 with a simultaneous handshake.
      load_and_advance(64'hA1B2C3D4E5F60718, 1'b1, 7);
      cycle(1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b1);
      check("abort_round", 64'(ROUND_NUM), 64'(0));
      check("abort_no_done", 64'(DONE), 64'(0));
      check("abort_k1", 64'(SUBKEY_OUT), 64'(des_subkey(64'h0123456789ABCDEF, 1)));
      run_to_done();

      // Asynchronous reset at round 10, then a fresh load.
      load_and_advance(64'hFEDCBA9876543210, 1'b1, 10);
      RST_N = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("rst_subkey_zero", 64'(SUBKEY_OUT), 64'(0));
      #1;
      RST_N = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 64'h5B5A57676A56676E, 1'b0, 1'b1);
      run_to_done();

      // Randomized traffic: random keys, directions, stalls and aborts.
      for (int i = 0; i < 1500; i++) begin
         rkey = {$urandom, $urandom};
         rdec = 1'($urandom_range(0, 1));
         rrdy = ($urandom_range(0, 3) != 0);
         if (m_active) rld = ($urandom_range(0, 63) == 0);
         else          rld = ($urandom_range(0, 3) == 0);
         cycle(rld, rkey, rdec, rrdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
